// File: rtl/gb_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// gb_interrupt_ctrl
//
// Game Boy interrupt controller. Holds the IF (FF0F) and IE (FFFF) registers
// and the IME master enable, arbitrates pending requests by fixed priority
// (bit 0 highest) and runs the CPU dispatch handshake:
//   IDLE --int_ack (while int_req)--> PUSH --int_sel--> IDLE (+vec_valid)
//
// Optional feature macro: GB_IE_PUSH_QUIRK_EN
//   defined   : the winner is re-evaluated from pending at int_sel, so IE/IF
//               writes during the PC push (e.g. the push landing on FFFF)
//               change the outcome; nothing pending gives vector 0000.
//   undefined : the winning index is latched at int_ack and issued at int_sel
//               regardless of later IE/IF changes.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   data_i[7:0]    IO bus write data
//   addr[15:0]     IO bus address
//   wren           IO bus write strobe
//   data_o[7:0]    combinational read data for addr
//   irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad
//                  one-cycle request pulses, IF bits 0..4
//   ime_set        EI/RETI effect, sets IME
//   ime_clear      DI effect, clears IME (wins over ime_set)
//   int_ack        CPU starts dispatch (pulse)
//   int_sel        CPU finished high-byte push, select vector (pulse)
//   int_req        dispatch request to the CPU
//   wake           HALT/STOP wakeup, any enabled pending bit (IME ignored)
//   ime            current IME
//   int_vector     dispatch target, holds between dispatches
//   vec_valid      one-cycle pulse, int_vector valid
// ---------------------------------------------------------------------------
module gb_interrupt_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_i,
  input  logic [15:0] addr,
  input  logic        wren,
  output logic [7:0]  data_o,
  input  logic        irq_vblank,
  input  logic        irq_stat,
  input  logic        irq_timer,
  input  logic        irq_serial,
  input  logic        irq_joypad,
  input  logic        ime_set,
  input  logic        ime_clear,
  input  logic        int_ack,
  input  logic        int_sel,
  output logic        int_req,
  output logic        wake,
  output logic        ime,
  output logic [15:0] int_vector,
  output logic        vec_valid
);

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PUSH = 1'b1
  } state_t;

  state_t      state;
  logic [4:0]  if_q;
  logic [7:0]  ie_q;
  logic        ime_q;
  logic [15:0] vector_q;
  logic        vec_valid_q;

  // Lowest set bit wins; caller qualifies with |vec.
  function automatic logic [2:0] prio_idx(input logic [4:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // 0040 + 8*idx; idx <= 4 only touches bits 5:3, so concatenation suffices.
  function automatic logic [15:0] vec_of(input logic [2:0] idx);
    return {8'h00, 2'b01, idx, 3'b000};
  endfunction

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic [4:0] irq_set;
  logic [4:0] pending;
  logic       any_pending;
  logic       ack_accept;
  logic       sel_fire;
  logic       wr_if;
  logic       wr_ie;

  assign irq_set     = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};
  assign pending     = ie_q[4:0] & if_q;
  assign any_pending = |pending;
  assign wake        = any_pending;
  assign int_req     = ime_q & any_pending & (state == ST_IDLE);
  assign ack_accept  = int_ack & int_req;
  assign sel_fire    = int_sel & (state == ST_PUSH);
  assign wr_if       = wren & (addr == ADDR_IF);
  assign wr_ie       = wren & (addr == ADDR_IE);

  // -------------------------------------------------------------------------
  // Vector selection at int_sel
  // -------------------------------------------------------------------------
  logic        sel_valid;   // a real source was selected (bit to clear)
  logic [2:0]  sel_idx;
  logic [15:0] sel_vector;
  logic [4:0]  clear_mask;

`ifdef GB_IE_PUSH_QUIRK_EN
  // Re-arbitrate on the live pending set; IE/IF may have moved during PUSH.
  assign sel_valid = any_pending;
  assign sel_idx   = prio_idx(pending);
`else
  logic [2:0] idx_q;        // winner frozen at int_ack

  assign sel_valid = 1'b1;
  assign sel_idx   = idx_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= 3'd0;
    end else if (ack_accept) begin
      idx_q <= prio_idx(pending);
    end
  end
`endif

  assign sel_vector = sel_valid ? vec_of(sel_idx) : 16'h0000;

  // NOTE: every output of an always_comb gets a default before any branch;
  // otherwise an unassigned path infers a latch.
  always_comb begin
    clear_mask = 5'b0;
    if (sel_fire && sel_valid) clear_mask[sel_idx] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // IF / IE / IME
  // -------------------------------------------------------------------------
  // Per-bit precedence: request set > dispatch clear > bus write.
  logic [4:0] if_next;

  always_comb begin
    if_next = if_q;
    if (wr_if) if_next = data_i[4:0];
    if_next = (if_next & ~clear_mask) | irq_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_q  <= 5'b0;
      ie_q  <= 8'h00;
      ime_q <= 1'b0;
    end else begin
      if_q <= if_next;
      if (wr_ie) ie_q <= data_i;
      // Clear (DI or an accepted dispatch) wins over set.
      if (ime_clear || ack_accept) ime_q <= 1'b0;
      else if (ime_set)            ime_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Dispatch FSM with registered vector outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      vector_q    <= 16'h0000;
      vec_valid_q <= 1'b0;
    end else begin
      vec_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Stray int_ack (no request) and stray int_sel are ignored here.
          if (ack_accept) state <= ST_PUSH;
        end
        ST_PUSH: begin
          // int_ack is ignored while the push is in progress.
          if (int_sel) begin
            vector_q    <= sel_vector;
            vec_valid_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ime        = ime_q;
  assign int_vector = vector_q;
  assign vec_valid  = vec_valid_q;

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  always_comb begin
    data_o = 8'hFF;
    if (addr == ADDR_IF)      data_o = {3'b111, if_q};
    else if (addr == ADDR_IE) data_o = ie_q;
  end

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gb_interrupt_ctrl
//
// Directed self-checking bench for gb_interrupt_ctrl. Inputs change 1 ns
// after a rising edge and outputs are sampled there too, i.e. they reflect
// the state after that edge. Expectations for the IE-overwrite case follow
// GB_IE_PUSH_QUIRK_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_gb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_i;
  logic [15:0] addr;
  logic        wren;
  logic [7:0]  data_o;
  logic        irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad;
  logic        ime_set, ime_clear, int_ack, int_sel;
  logic        int_req, wake, ime;
  logic [15:0] int_vector;
  logic        vec_valid;

  int checks = 0;
  int errors = 0;

  gb_interrupt_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .data_i     (data_i),
    .addr       (addr),
    .wren       (wren),
    .data_o     (data_o),
    .irq_vblank (irq_vblank),
    .irq_stat   (irq_stat),
    .irq_timer  (irq_timer),
    .irq_serial (irq_serial),
    .irq_joypad (irq_joypad),
    .ime_set    (ime_set),
    .ime_clear  (ime_clear),
    .int_ack    (int_ack),
    .int_sel    (int_sel),
    .int_req    (int_req),
    .wake       (wake),
    .ime        (ime),
    .int_vector (int_vector),
    .vec_valid  (vec_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_i = d; wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, {24'h0, data_o}, {24'h0, exp});
  endtask

  task automatic pulse_ime_set();
    ime_set = 1'b1; tick(); ime_set = 1'b0;
  endtask

  // Full handshake: ack, then sel one cycle later; checks IME drop and vector.
  task automatic dispatch(input string tag, input logic [15:0] exp_vec);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check({tag, "_ime_after_ack"}, {31'h0, ime}, 32'h0);
    check({tag, "_req_after_ack"}, {31'h0, int_req}, 32'h0);
    int_sel = 1'b1; tick(); int_sel = 1'b0;
    check({tag, "_vec_valid"}, {31'h0, vec_valid}, 32'h1);
    check({tag, "_vector"}, {16'h0, int_vector}, {16'h0, exp_vec});
    tick();
    check({tag, "_vec_valid_drop"}, {31'h0, vec_valid}, 32'h0);
    check({tag, "_vector_hold"}, {16'h0, int_vector}, {16'h0, exp_vec});
  endtask

  initial begin
    reset = 1'b0; data_i = 8'h00; addr = 16'h0000; wren = 1'b0;
    irq_vblank = 1'b0; irq_stat = 1'b0; irq_timer = 1'b0;
    irq_serial = 1'b0; irq_joypad = 1'b0;
    ime_set = 1'b0; ime_clear = 1'b0; int_ack = 1'b0; int_sel = 1'b0;

    // Reset state
    tick(); tick();
    reset = 1'b1;
    check_read("rst_if", 16'hFF0F, 8'hE0);
    check_read("rst_ie", 16'hFFFF, 8'h00);
    check("rst_int_req", {31'h0, int_req}, 32'h0);
    check("rst_ime", {31'h0, ime}, 32'h0);
    check("rst_wake", {31'h0, wake}, 32'h0);
    check("rst_vec_valid", {31'h0, vec_valid}, 32'h0);
    check("rst_vector", {16'h0, int_vector}, 32'h0);
    check_read("other_addr", 16'hFF07, 8'hFF);

    // Timer interrupt dispatch
    bus_write(16'hFFFF, 8'h04);
    pulse_ime_set();
    check("ime_set", {31'h0, ime}, 32'h1);
    irq_timer = 1'b1; tick(); irq_timer = 1'b0;
    check_read("timer_if", 16'hFF0F, 8'hE4);
    check("timer_req", {31'h0, int_req}, 32'h1);
    check("timer_wake", {31'h0, wake}, 32'h1);
    dispatch("timer", 16'h0050);
    check_read("timer_if_clr", 16'hFF0F, 8'hE0);

    // Two simultaneous sources, priority order
    bus_write(16'hFFFF, 8'h1F);
    irq_joypad = 1'b1; irq_stat = 1'b1; tick();
    irq_joypad = 1'b0; irq_stat = 1'b0;
    check_read("dual_if", 16'hFF0F, 8'hF2);
    pulse_ime_set();
    dispatch("stat", 16'h0048);
    check_read("stat_if_clr", 16'hFF0F, 8'hF0);
    check("ime_after_stat", {31'h0, ime}, 32'h0);
    pulse_ime_set();
    dispatch("joypad", 16'h0060);
    check_read("joypad_if_clr", 16'hFF0F, 8'hE0);

    // IME=0: wake without request; clear beats set; stray ack/sel ignored
    bus_write(16'hFFFF, 8'h01);
    irq_vblank = 1'b1; tick(); irq_vblank = 1'b0;
    check("wake_no_ime", {31'h0, wake}, 32'h1);
    check("req_no_ime", {31'h0, int_req}, 32'h0);
    ime_set = 1'b1; ime_clear = 1'b0; ime_clear = 1'b1; tick();
    ime_set = 1'b0; ime_clear = 1'b0;
    check("ime_clear_wins", {31'h0, ime}, 32'h0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_sel = 1'b1; tick(); int_sel = 1'b0;
    check("stray_sel_no_valid", {31'h0, vec_valid}, 32'h0);
    check_read("stray_if_kept", 16'hFF0F, 8'hE1);
    pulse_ime_set();
    check("req_after_stray", {31'h0, int_req}, 32'h1);
    dispatch("vblank", 16'h0040);
    check_read("vblank_if_clr", 16'hFF0F, 8'hE0);

    // Upper IE bits read back but do not mask
    bus_write(16'hFFFF, 8'hE0);
    check_read("ie_upper", 16'hFFFF, 8'hE0);
    bus_write(16'hFF0F, 8'h1F);
    check("ie_upper_no_wake", {31'h0, wake}, 32'h0);
    bus_write(16'hFF0F, 8'h00);

    // Request set beats bus write of the same register
    addr = 16'hFF0F; data_i = 8'h00; wren = 1'b1; irq_serial = 1'b1;
    tick();
    wren = 1'b0; irq_serial = 1'b0;
    check_read("irq_over_write", 16'hFF0F, 8'hE8);
    bus_write(16'hFF0F, 8'h00);

    // Request set beats dispatch clear
    bus_write(16'hFFFF, 8'h01);
    bus_write(16'hFF0F, 8'h01);
    pulse_ime_set();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_sel = 1'b1; irq_vblank = 1'b1; tick();
    int_sel = 1'b0; irq_vblank = 1'b0;
    check("irq_over_clr_vec", {16'h0, int_vector}, 32'h0040);
    check_read("irq_over_clr_if", 16'hFF0F, 8'hE1);

    // Bus write then dispatch clear in the same cycle
    pulse_ime_set();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    addr = 16'hFF0F; data_i = 8'h05; wren = 1'b1; int_sel = 1'b1; tick();
    wren = 1'b0; int_sel = 1'b0;
    check_read("write_then_clr", 16'hFF0F, 8'hE4);
    bus_write(16'hFF0F, 8'h00);

    // IE overwritten during PUSH
    bus_write(16'hFF0F, 8'h01);
    pulse_ime_set();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    bus_write(16'hFFFF, 8'h00);
    int_sel = 1'b1; tick(); int_sel = 1'b0;
    check("push_ie_valid", {31'h0, vec_valid}, 32'h1);
`ifdef GB_IE_PUSH_QUIRK_EN
    check("push_ie_vector", {16'h0, int_vector}, 32'h0000);
    check_read("push_ie_if", 16'hFF0F, 8'hE1);
`else
    check("push_ie_vector", {16'h0, int_vector}, 32'h0040);
    check_read("push_ie_if", 16'hFF0F, 8'hE0);
`endif

    // Reset in the middle of a dispatch
    bus_write(16'hFFFF, 8'h01);
    bus_write(16'hFF0F, 8'h01);
    pulse_ime_set();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reset = 1'b0; tick(); reset = 1'b1;
    check("midrst_vec_valid", {31'h0, vec_valid}, 32'h0);
    check("midrst_vector", {16'h0, int_vector}, 32'h0);
    check("midrst_ime", {31'h0, ime}, 32'h0);
    check_read("midrst_if", 16'hFF0F, 8'hE0);
    check_read("midrst_ie", 16'hFFFF, 8'h00);
    int_sel = 1'b1; tick(); int_sel = 1'b0;
    check("midrst_sel_ignored", {31'h0, vec_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_interrupt_ctrl.md
# gb_interrupt_ctrl

Game Boy interrupt controller between the peripheral interrupt sources (VBlank, STAT, timer, serial, joypad) and the CPU core. Holds the memory-mapped IF (FF0F) and IE (FFFF) registers plus the IME master enable. Arbitrates pending requests by fixed priority and sequences the CPU's dispatch handshake, producing the jump vector. Sits on the same IO bus as `gb_timer`, whose `irq_timer` it consumes.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `data_i` in 8: IO bus write data.
- `addr` in 16: IO bus address.
- `wren` in 1: IO bus write strobe, sampled on rising edge.
- `data_o` out 8: combinational read data for `addr`.
- `irq_vblank`, `irq_stat`, `irq_timer`, `irq_serial`, `irq_joypad` in 1 each: one-cycle request pulses, IF bits 0..4.
- `ime_set` in 1: CPU EI/RETI effect; sets IME.
- `ime_clear` in 1: CPU DI effect; clears IME.
- `int_ack` in 1: CPU starts dispatch (one-cycle pulse).
- `int_sel` in 1: CPU finished high-byte PC push; select vector now (one-cycle pulse).
- `int_req` out 1: interrupt dispatch requested.
- `wake` out 1: HALT/STOP wakeup; any enabled pending bit, IME ignored.
- `ime` out 1: current IME.
- `int_vector` out 16: dispatch target.
- `vec_valid` out 1: `int_vector` valid, one-cycle pulse.

## Operation
- IF[4:0]: `irq_*` pulse sets its bit. Bus write to FF0F loads `data_i[4:0]`. Read FF0F = `{3'b111, IF[4:0]}`.
- IE[7:0]: bus write to FFFF loads all 8 bits. Read returns all 8 bits. Only IE[4:0] masks.
- `data_o` = 8'hFF for any other address.
- `pending` = IE[4:0] & IF[4:0]. Priority: bit 0 is highest, bit 4 lowest. Vector = 16'h0040 + 8*idx (0040/0048/0050/0058/0060).
- `wake` = |pending. `int_req` = IME & |pending & (state==IDLE). Both are combinational from registers.
- IME update: `ime_clear` or an accepted `int_ack` clears IME. Otherwise `ime_set` sets it. Clear wins over set.
- FSM:
  - IDLE: `int_ack` while `int_req`=1 moves to PUSH and clears IME. A stray `int_ack` (`int_req`=0) is ignored. A stray `int_sel` in IDLE is also ignored.
  - PUSH: waits for `int_sel`. On `int_sel`, selects the vector (see Configuration), clears the selected IF bit, registers `int_vector`, pulses `vec_valid` the next cycle, then returns to IDLE.
  - `int_ack` in PUSH is ignored.
- Same-cycle IF precedence, per bit: `irq_*` set > dispatch clear > bus write. Bus write and dispatch clear in the same cycle: apply the write, then clear the selected bit.
- `int_vector` holds its last value between dispatches.

## Timing
- Reset values: IF=0 (reads 8'hE0), IE=8'h00, IME=0, state IDLE, `int_vector`=16'h0000, `vec_valid`=0. Hence `int_req`=0, `wake`=0, `ime`=0.
- Reset mid-dispatch: returns to IDLE, no `vec_valid`, IF unchanged only by reset clearing.
- `irq_*` pulse at edge N: IF bit visible after edge N. `int_req` and `wake` assert in cycle N+1 if enabled.
- Bus write at edge N: register visible to `data_o` after edge N.
- `int_ack` at edge N: IME=0 and `int_req`=0 after N.
- `int_sel` at edge M: `vec_valid`=1 and `int_vector` valid during cycle M+1; IF bit cleared after M. IDLE after M; `int_req` can assert from M+1 if IME was re-set.

## Configuration
- `GB_IE_PUSH_QUIRK_EN` defined:
  - Priority is re-evaluated from `pending` at `int_sel`, so IE/IF changes during PUSH (e.g. the push overwriting FFFF) change the outcome.
  - If `pending`==0 at `int_sel`, `int_vector`=16'h0000, no IF bit is cleared, and `vec_valid` still pulses.
- Undefined:
  - The priority index is latched at `int_ack`.
  - At `int_sel`, that latched bit is cleared and its vector is issued, regardless of intervening IE/IF changes.

## Test plan
- Reset with `reset`=0: read FF0F -> 8'hE0, FFFF -> 8'h00, `int_req`=0, `ime`=0.
- Write FFFF=8'h04, FF07=8'h05 to `gb_timer`, TIMA=8'hFF, `ime_set`: after overflow `irq_timer` sets IF=8'hE4, `int_req`=1. Then `int_ack`, `int_sel` -> `int_vector`=16'h0050, `vec_valid` for 1 cycle, IF reads 8'hE0, `ime`=0.
- IE=8'h1F, pulse `irq_joypad` and `irq_stat` together, IME=1: dispatch yields 16'h0048, IF reads 8'hF0. A second dispatch yields 16'h0060.
- IME=0, IE=8'h01, `irq_vblank`: `wake`=1, `int_req`=0. Same cycle `ime_set`+`ime_clear` -> `ime`=0.
- Same-cycle write FF0F=8'h00 with `irq_serial` pulse: IF reads 8'hE8.
- IE=8'h01, IF bit0 pending, `int_ack`, then write FFFF=8'h00 before `int_sel`:
  - with `GB_IE_PUSH_QUIRK_EN`: vector 16'h0000, IF bit0 stays set;
  - without it: vector 16'h0040, IF bit0 cleared.
